// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between decode and the hazard-control unit.
// master: the decode/pipeline side, which drives the instruction and ID/EX fields.
// slave : the hazard unit, which returns the pipeline controls and FP scoreboard view.
// Control semantics: stall freezes PC and IF/ID, idexBubble loads a bubble into
// ID/EX, and ifidFlush squashes IF/ID. All three are level signals that apply to
// the cycle in which they are asserted. There is no handshake.
interface id_hazard_ctrl_if;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        idUsesRs;
  logic        idUsesRt;
  logic        idFloatSrc;
  logic [1:0]  idFpOp;
  logic [4:0]  idFpDst;
  logic [4:0]  exDstReg;
  logic        exRWrite;
  logic        exFloat;
  logic [2:0]  exWBsrc;
  logic        branchTaken;
  logic        stall;
  logic        idexBubble;
  logic        ifidFlush;
  logic        fpBusy;
  logic [4:0]  fpBusyDst;
  logic [31:0] statStallCycles;
  logic [31:0] statFlushes;

  modport master (
    output idRs, idRt, idUsesRs, idUsesRt, idFloatSrc, idFpOp, idFpDst,
           exDstReg, exRWrite, exFloat, exWBsrc, branchTaken,
    input  stall, idexBubble, ifidFlush, fpBusy, fpBusyDst,
           statStallCycles, statFlushes
  );

  modport slave (
    input  idRs, idRt, idUsesRs, idUsesRt, idFloatSrc, idFpOp, idFpDst,
           exDstReg, exRWrite, exFloat, exWBsrc, branchTaken,
    output stall, idexBubble, ifidFlush, fpBusy, fpBusyDst,
           statStallCycles, statFlushes
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard control: load-use detection against ID/EX, plus a
// one-entry scoreboard for the multi-cycle FP mul/div unit.
// Optional macro HAZARD_STATS_EN adds stall-cycle and flush counters. Without
// it, both stat outputs read 0 and no counter flops exist.
module id_hazard_ctrl #(
  parameter int       FP_MUL_LAT = 4,
  parameter int       FP_DIV_LAT = 12,
  parameter logic [2:0] LOAD_WBSRC = 3'd1
) (
  input logic          clk,
  input logic          rst_n,
  id_hazard_ctrl_if.slave hif
);

  // The count loaded at issue excludes the issue cycle itself.
  localparam logic [3:0] MUL_CNT = 4'(FP_MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(FP_DIV_LAT - 1);

  logic [3:0] cnt;
  logic [3:0] cntNext;
  logic [4:0] busyDst;
  logic [4:0] busyDstNext;
  logic       unitBusy;
  logic       loadHaz;
  logic       fpStruct;
  logic       fpRaw;
  logic       haz;
  logic       isMulDiv;
  logic       issue;
  logic       stallInt;
  logic       bubbleInt;
  logic       flushInt;

  // Hazard detection, evaluated from the current decode and ID/EX contents.
  always_comb begin
    unitBusy = (cnt != 4'd0);
    loadHaz  = hif.exRWrite && (hif.exWBsrc == LOAD_WBSRC) &&
               (hif.exFloat == hif.idFloatSrc) &&
               ((hif.idUsesRs && (hif.idRs == hif.exDstReg)) ||
                (hif.idUsesRt && (hif.idRt == hif.exDstReg))) &&
               (hif.idFloatSrc || (hif.exDstReg != 5'd0));
    fpStruct = unitBusy && (hif.idFpOp != 2'd0);
    fpRaw    = unitBusy && hif.idFloatSrc &&
               ((hif.idUsesRs && (hif.idRs == busyDst)) ||
                (hif.idUsesRt && (hif.idRt == busyDst)));
    haz      = loadHaz || fpStruct || fpRaw;
    isMulDiv = (hif.idFpOp == 2'd2) || (hif.idFpOp == 2'd3);
  end

  // Pipeline controls. Reset forces a flush, and a taken branch overrides any hazard.
  always_comb begin
    stallInt  = 1'b0;
    bubbleInt = 1'b0;
    flushInt  = 1'b0;
    if (!rst_n) begin
      bubbleInt = 1'b1;
      flushInt  = 1'b1;
    end else if (hif.branchTaken) begin
      bubbleInt = 1'b1;
      flushInt  = 1'b1;
    end else begin
      stallInt  = haz;
      bubbleInt = haz;
    end
    issue = rst_n && isMulDiv && !stallInt && !hif.branchTaken;
  end

  // Scoreboard next state: load on issue, otherwise count down to idle.
  always_comb begin
    cntNext     = cnt;
    busyDstNext = busyDst;
    if (issue) begin
      cntNext     = (hif.idFpOp == 2'd2) ? MUL_CNT : DIV_CNT;
      busyDstNext = hif.idFpDst;
    end else if (cnt != 4'd0) begin
      cntNext = cnt - 4'd1;
    end
  end

  // Scoreboard state register. Reset abandons any in-flight mul/div.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      busyDst <= 5'd0;
    end else begin
      cnt     <= cntNext;
      busyDst <= busyDstNext;
    end
  end

  assign hif.stall      = stallInt;
  assign hif.idexBubble = bubbleInt;
  assign hif.ifidFlush  = flushInt;
  assign hif.fpBusy     = rst_n && unitBusy;
  assign hif.fpBusyDst  = rst_n ? busyDst : 5'd0;

`ifdef HAZARD_STATS_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  // Free-running event counters. They wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt <= 32'd0;
      flushCnt <= 32'd0;
    end else begin
      if (stallInt)        stallCnt <= stallCnt + 32'd1;
      if (hif.branchTaken) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign hif.statStallCycles = stallCnt;
  assign hif.statFlushes     = flushCnt;
`else
  assign hif.statStallCycles = 32'd0;
  assign hif.statFlushes     = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl. It applies a vector table, then runs
// hand-written multi-cycle sequences for the FP scoreboard, reset and the stat counters.
module tb_id_hazard_ctrl;
  localparam int W = 9; // {stall, idexBubble, ifidFlush, fpBusy, fpBusyDst}

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] exp_q[$];

  id_hazard_ctrl_if hif ();

  id_hazard_ctrl #(.FP_MUL_LAT(4), .FP_DIV_LAT(12), .LOAD_WBSRC(3'd1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif.slave)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required $finish before timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uRs;
    logic       uRt;
    logic       fsrc;
    logic [1:0] fpOp;
    logic [4:0] fpDst;
    logic [4:0] exDst;
    logic       exW;
    logic       exF;
    logic [2:0] wb;
    logic       br;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [W-1:0] ex(input logic s, input logic b, input logic f,
                                      input logic busy, input logic [4:0] d);
    return {s, b, f, busy, d};
  endfunction

  // Drivers.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uRs,
                       input logic uRt, input logic fsrc, input logic [1:0] fpOp,
                       input logic [4:0] fpDst, input logic [4:0] exDst, input logic exW,
                       input logic exF, input logic [2:0] wb, input logic br);
    hif.idRs = rs;        hif.idRt = rt;
    hif.idUsesRs = uRs;   hif.idUsesRt = uRt;
    hif.idFloatSrc = fsrc; hif.idFpOp = fpOp; hif.idFpDst = fpDst;
    hif.exDstReg = exDst; hif.exRWrite = exW; hif.exFloat = exF;
    hif.exWBsrc = wb;     hif.branchTaken = br;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // Scoreboard: push the expectation with the stimulus, then pop and compare
  // mid-cycle while the combinational outputs are stable.
  task automatic check_cycle(input string name, input logic [W-1:0] e);
    logic [W-1:0] act;
    logic [W-1:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    act  = {hif.stall, hif.idexBubble, hif.ifidFlush, hif.fpBusy, hif.fpBusyDst};
    want = exp_q.pop_front();
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got stall/bub/flush/busy/dst=%b, expected %b", name, act, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string name, input logic [31:0] s, input logic [31:0] f);
    n_checks++;
    if (hif.statStallCycles !== s || hif.statFlushes !== f) begin
      n_errors++;
      $display("FAIL %s: got stalls=%0d flushes=%0d, expected stalls=%0d flushes=%0d",
               name, hif.statStallCycles, hif.statFlushes, s, f);
    end
  endtask

  initial begin
    logic [31:0] expStalls;
    logic [31:0] expFlushes;
    n_checks = 0;
    n_errors = 0;

    //                name         rs rt uRs uRt fs op dst exD exW exF wb br exp
    tbl[0]  = '{"lu_rs",       5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, ex(1,1,0,0,0)};
    tbl[1]  = '{"lu_rt",       0, 5, 0, 1, 0, 0, 0, 5, 1, 0, 1, 0, ex(1,1,0,0,0)};
    tbl[2]  = '{"lu_unused",   5, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1, 0, ex(0,0,0,0,0)};
    tbl[3]  = '{"gpr_zero",    0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, ex(0,0,0,0,0)};
    tbl[4]  = '{"fpr_f0",      0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0, ex(1,1,0,0,0)};
    tbl[5]  = '{"dom_int_fp",  5, 0, 1, 0, 1, 0, 0, 5, 1, 0, 1, 0, ex(0,0,0,0,0)};
    tbl[6]  = '{"dom_fp_int",  5, 0, 1, 0, 0, 0, 0, 5, 1, 1, 1, 0, ex(0,0,0,0,0)};
    tbl[7]  = '{"not_load",    5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 2, 0, ex(0,0,0,0,0)};
    tbl[8]  = '{"no_write",    5, 0, 1, 0, 0, 0, 0, 5, 0, 0, 1, 0, ex(0,0,0,0,0)};
    tbl[9]  = '{"br_prio",     5, 0, 1, 0, 0, 3, 9, 5, 1, 0, 1, 1, ex(0,1,1,0,0)};
    tbl[10] = '{"br_no_issue", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0)};
    tbl[11] = '{"fp_add",      1, 2, 1, 1, 1, 1, 4, 0, 0, 0, 0, 0, ex(0,0,0,0,0)};
    tbl[12] = '{"add_no_load", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0)};

    // Reset phase.
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    check_cycle("reset_hold", ex(0,1,1,0,0));
    rst_n = 1'b1;
    check_cycle("reset_release", ex(0,0,0,0,0));

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uRs, tbl[i].uRt, tbl[i].fsrc, tbl[i].fpOp,
            tbl[i].fpDst, tbl[i].exDst, tbl[i].exW, tbl[i].exF, tbl[i].wb, tbl[i].br);
      check_cycle(tbl[i].name, tbl[i].exp);
    end

    // Load-use lasts one cycle: once ID/EX holds the bubble, the hazard clears.
    drive(5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
    check_cycle("lu_seq_stall", ex(1,1,0,0,0));
    drive(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("lu_seq_clear", ex(0,0,0,0,0));

    // FP divide to f8: a reader of f8 stalls 11 cycles and proceeds on the 12th.
    drive(0, 0, 0, 0, 0, 3, 8, 0, 0, 0, 0, 0);
    check_cycle("div_issue", ex(0,0,0,0,0));
    for (int i = 0; i < 11; i++) begin
      drive(8, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      check_cycle($sformatf("div_raw_%0d", i), ex(1,1,0,1,8));
    end
    check_cycle("div_proceed", ex(0,0,0,0,8));

    // FP multiply in flight (cnt=3): an FP add is a structural hazard for 3 cycles.
    drive(0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0);
    check_cycle("mul_issue", ex(0,0,0,0,8));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 1, 1, 4, 0, 0, 0, 0, 0);
      check_cycle($sformatf("mul_struct_%0d", i), ex(1,1,0,1,3));
    end
    check_cycle("mul_add_go", ex(0,0,0,0,3));
    idle();
    check_cycle("add_no_sb", ex(0,0,0,0,3));

    // An integer op reading $3 runs freely while f3 is busy.
    drive(0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0);
    check_cycle("mul2_issue", ex(0,0,0,0,3));
    for (int i = 0; i < 3; i++) begin
      drive(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_cycle($sformatf("int_free_%0d", i), ex(0,0,0,1,3));
    end
    check_cycle("mul2_done", ex(0,0,0,0,3));

    // All three hazards at once produce one combined stall.
    drive(0, 0, 0, 0, 0, 2, 6, 0, 0, 0, 0, 0);
    check_cycle("mul3_issue", ex(0,0,0,0,3));
    drive(6, 0, 1, 0, 1, 1, 7, 6, 1, 1, 1, 0);
    check_cycle("combined", ex(1,1,0,1,6));
    idle();
    check_cycle("mul3_cnt2", ex(0,0,0,1,6));
    check_cycle("mul3_cnt1", ex(0,0,0,1,6));
    check_cycle("mul3_done", ex(0,0,0,0,6));

    // Reset at cnt=7 abandons the divide.
    drive(0, 0, 0, 0, 0, 3, 8, 0, 0, 0, 0, 0);
    check_cycle("div2_issue", ex(0,0,0,0,6));
    idle();
    for (int i = 0; i < 4; i++) check_cycle($sformatf("div2_busy_%0d", i), ex(0,0,0,1,8));
    rst_n = 1'b0;
    check_cycle("midop_reset", ex(0,1,1,0,0));
    rst_n = 1'b1;
    drive(8, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("post_reset", ex(0,0,0,0,0));
    check_stats("stats_cleared", 32'd0, 32'd0);

    // Five stall cycles followed by two taken-branch cycles.
    for (int i = 0; i < 5; i++) begin
      drive(5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
      check_cycle($sformatf("st_stall_%0d", i), ex(1,1,0,0,0));
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_cycle($sformatf("st_flush_%0d", i), ex(0,1,1,0,0));
    end
`ifdef HAZARD_STATS_EN
    expStalls  = 32'd5;
    expFlushes = 32'd2;
`else
    expStalls  = 32'd0;
    expFlushes = 32'd0;
`endif
    check_stats("stats_count", expStalls, expFlushes);

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
